// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate sequencer for a frequency counter.
// Runs IDLE -> CLR -> CNT -> LOCK, driving clear/enable/lock strobes for an
// external counter and tracking the elapsed gate length in gate_cnt_o.
// Optional feature: define FREQ_GATE_OVF_EN to add ovf_i/ovf_o, letting a
// saturated counter end the gate early and flagging it until the next clear.
module freq_gate_ctrl #(
  parameter int GATE_W   = 24,
  parameter int CLR_LEN  = 1,
  parameter int LOCK_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic              abort_i,
  input  logic [GATE_W-1:0] gate_len_i,
`ifdef FREQ_GATE_OVF_EN
  input  logic              ovf_i,
`endif
  output logic              clear_o,
  output logic              count_en_o,
  output logic              lock_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [GATE_W-1:0] gate_cnt_o
`ifdef FREQ_GATE_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_CNT, S_LOCK} state_t;

  localparam logic [3:0]        CLR_LEN_C  = 4'(CLR_LEN);
  localparam logic [3:0]        LOCK_LEN_C = 4'(LOCK_LEN);
  localparam logic [GATE_W-1:0] ONE_C      = GATE_W'(1);

  state_t              state_q, state_d;
  logic [3:0]          ph_q, ph_d;          // cycle index inside CLR / LOCK, 1-based
  logic [GATE_W-1:0]   gate_len_q, gate_len_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic                abort_seen_q, abort_seen_d;  // abort seen during LOCK
  logic                clear_q, clear_d;
  logic                count_en_q, count_en_d;
  logic                lock_q, lock_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                enter_clr;
  logic                ovf_hit;

`ifdef FREQ_GATE_OVF_EN
  assign ovf_hit = ovf_i;
`else
  assign ovf_hit = 1'b0;
`endif

  // Next-state logic plus registered output decodes taken from the next state,
  // so each strobe is valid in the very cycle the FSM sits in its state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    ph_d         = ph_q;
    gate_len_d   = gate_len_q;
    gate_cnt_d   = gate_cnt_q;
    abort_seen_d = abort_seen_q;
    enter_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) enter_clr = 1'b1;
      end
      S_CLR: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (ph_q == CLR_LEN_C) begin
          state_d    = S_CNT;
          gate_cnt_d = gate_cnt_q + ONE_C;  // first CNT cycle shows 1
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      S_CNT: begin
        // Compare before incrementing: the count tops out at gate_len_q,
        // so even an all-ones length never wraps.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (gate_cnt_q == gate_len_q || ovf_hit) begin
          state_d      = S_LOCK;
          ph_d         = 4'd1;
          abort_seen_d = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + ONE_C;
        end
      end
      S_LOCK: begin
        // Abort never shortens the lock; it is remembered and applied at exit.
        abort_seen_d = abort_seen_q | abort_i;
        if (ph_q == LOCK_LEN_C) begin
          abort_seen_d = 1'b0;
          if (cont_i && !abort_i && !abort_seen_q) enter_clr = 1'b1;
          else                                     state_d   = S_IDLE;
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_clr) begin
      state_d    = S_CLR;
      ph_d       = 4'd1;
      gate_cnt_d = '0;
      gate_len_d = (gate_len_i == '0) ? ONE_C : gate_len_i;
    end

    clear_d    = (state_d == S_CLR);
    count_en_d = (state_d == S_CNT);
    lock_d     = (state_d == S_LOCK);
    done_d     = (state_d == S_LOCK) && (ph_d == LOCK_LEN_C);
    busy_d     = (state_d != S_IDLE);
  end

  // State, counters and output flops; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      gate_len_q   <= '0;
      gate_cnt_q   <= '0;
      abort_seen_q <= 1'b0;
      clear_q      <= 1'b0;
      count_en_q   <= 1'b0;
      lock_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      gate_len_q   <= gate_len_d;
      gate_cnt_q   <= gate_cnt_d;
      abort_seen_q <= abort_seen_d;
      clear_q      <= clear_d;
      count_en_q   <= count_en_d;
      lock_q       <= lock_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign clear_o    = clear_q;
  assign count_en_o = count_en_q;
  assign lock_o     = lock_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign gate_cnt_o = gate_cnt_q;

`ifdef FREQ_GATE_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow flag: set on an early LOCK entry, held until the next CLR entry.
  always_comb begin
    ovf_d = ovf_q;
    if (enter_clr)
      ovf_d = 1'b0;
    else if (state_q == S_CNT && state_d == S_LOCK && ovf_i)
      ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

endmodule
